// File: rtl/reg_seq_pkg.sv
// -----------------------------------------------------------------------------
// reg_seq_pkg
//   Shared definitions for the register-file bulk-access sequencer:
//   default geometry of the register file, the command mode encoding and
//   the sequencer state encoding.
// -----------------------------------------------------------------------------
package reg_seq_pkg;

    // Default register-file geometry.
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;

    // Command mode, sampled together with start.
    localparam logic MODE_DUMP = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RD,
        ST_WAIT,
        ST_DONE
    } state_t;

endpackage : reg_seq_pkg

// File: rtl/reg_addr_seq.sv
// -----------------------------------------------------------------------------
// reg_addr_seq
//   Address counter for the sequencer. It is cleared at command launch,
//   advanced one register per step and reports when it sits on the last
//   register. It saturates at the last register and never wraps.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset, clears the address
//   clear  in   load address 0 (takes priority over step)
//   step   in   advance to the next register
//   addr   out  current register address
//   last   out  1 when addr is the last register of the walk
// -----------------------------------------------------------------------------
module reg_addr_seq
    import reg_seq_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr <= '0;
        end else if (clear) begin
            addr <= '0;
        end else if (step && !last) begin
            addr <= addr + 1'b1;
        end
    end

    assign last = (addr == LAST_ADDR);

endmodule : reg_addr_seq

// File: rtl/reg_file_sequencer.sv
// -----------------------------------------------------------------------------
// reg_file_sequencer
//   Bulk-access master for the register file. FILL writes every register
//   with a base value (optionally plus its address); DUMP reads every
//   register and streams {addr,data} over a valid/ready port. While busy=1
//   the top-level mux hands this block the file's ports.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   start        in   command strobe, honoured only in IDLE
//   mode         in   with start: 0 = DUMP, 1 = FILL
//   fill_inc     in   with start: 1 = write fill_base+addr, 0 = fill_base
//   fill_base    in   with start: fill value
//   abort        in   synchronous cancel, any state -> IDLE, no done
//   busy         out  1 in every state except IDLE
//   done         out  one-cycle pulse on command completion
//   rf_r_addr    out  file read address (combinational read)
//   rf_r_data    in   file read data
//   rf_w_addr    out  file write address
//   rf_w_data    out  file write data
//   rf_write_en  out  file write enable, 1 only while filling
//   out_valid    out  dump word valid
//   out_ready    in   dump word accepted when valid & ready
//   out_addr     out  register index of out_data
//   out_data     out  register contents
// -----------------------------------------------------------------------------
module reg_file_sequencer
    import reg_seq_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              fill_inc,
    input  logic [DATA_W-1:0] fill_base,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_r_addr,
    input  logic [DATA_W-1:0] rf_r_data,
    output logic [ADDR_W-1:0] rf_w_addr,
    output logic [DATA_W-1:0] rf_w_data,
    output logic              rf_write_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic              addr_last;
    logic              addr_clear;
    logic              addr_step;
    logic              cmd_load;
    logic              capture;
    logic [DATA_W-1:0] base_q;
    logic              inc_q;

    reg_addr_seq #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_addr_seq (
        .clk   (clk),
        .reset (reset),
        .clear (addr_clear),
        .step  (addr_step),
        .addr  (addr),
        .last  (addr_last)
    );

    // -------------------------------------------------------------------------
    // Next-state logic. abort overrides everything, including a start seen
    // in IDLE, and suppresses every side effect of the cycle.
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        addr_clear = 1'b0;
        addr_step  = 1'b0;
        cmd_load   = 1'b0;
        capture    = 1'b0;

        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        cmd_load   = 1'b1;
                        addr_clear = 1'b1;
                        state_next = (mode == MODE_FILL) ? ST_FILL : ST_RD;
                    end
                end
                ST_FILL: begin
                    if (addr_last) begin
                        state_next = ST_DONE;
                    end else begin
                        addr_step = 1'b1;
                    end
                end
                ST_RD: begin
                    capture    = 1'b1;
                    state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    if (out_ready) begin
                        if (addr_last) begin
                            state_next = ST_DONE;
                        end else begin
                            addr_step  = 1'b1;
                            state_next = ST_RD;
                        end
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command operands and the dump output word. These are cleared on reset
    // as well because every output, including out_addr/out_data and the
    // write data derived from base/inc, must read 0 while reset is held.
    // NOTE: datapath registers are reset here only because their values are
    // directly visible on outputs during reset, not for functional safety.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q   <= '0;
            inc_q    <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
        end else begin
            if (cmd_load) begin
                base_q <= fill_base;
                inc_q  <= fill_inc;
            end
            if (capture) begin
                out_addr <= addr;
                out_data <= rf_r_data;
            end
        end
    end

    // out_valid is exactly "in WAIT": abort or reset drop it with the state.
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign out_valid   = (state == ST_WAIT);
    assign rf_write_en = (state == ST_FILL);
    assign rf_r_addr   = addr;
    assign rf_w_addr   = addr;
    assign rf_w_data   = base_q + (inc_q ? DATA_W'(addr) : '0);

endmodule : reg_file_sequencer

// File: tb/tb_reg_file_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sequencer
//   Bench for reg_file_sequencer driving a behavioural 32x32 register file.
//   Expected write and dump streams are built from the fill rule
//   (base + inc*k) and a model of the register contents; a negedge monitor
//   scores every write and every accepted dump word against them, and the
//   directed sequence adds literal cycle-count and content expectations.
// -----------------------------------------------------------------------------
module tb_reg_file_sequencer;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } word_t;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          start     = 1'b0;
    logic          mode      = 1'b0;
    logic          fill_inc  = 1'b0;
    logic [DW-1:0] fill_base = '0;
    logic          abort     = 1'b0;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          rf_write_en;
    logic          out_valid;
    logic [AW-1:0] rf_r_addr;
    logic [AW-1:0] rf_w_addr;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] rf_r_data;
    logic [DW-1:0] rf_w_data;
    logic [DW-1:0] out_data;

    logic [DW-1:0] rf_mem    [NR];
    logic [DW-1:0] model_mem [NR];
    word_t         exp_wr[$];
    word_t         exp_dump[$];

    int n_checks     = 0;
    int n_errors     = 0;
    int done_cnt     = 0;
    int busy_cycles  = 0;
    int valid_cycles = 0;
    int stall_cycles = 0;
    int words_seen   = 0;
    int stall_addr   = -1;
    int stall_len    = 0;
    int stall_done   = 0;

    reg_file_sequencer #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .NUM_REGS (NR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .fill_inc    (fill_inc),
        .fill_base   (fill_base),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .rf_r_addr   (rf_r_addr),
        .rf_r_data   (rf_r_data),
        .rf_w_addr   (rf_w_addr),
        .rf_w_data   (rf_w_data),
        .rf_write_en (rf_write_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data)
    );

    always #5 clk = ~clk;

    // Target register file: combinational read, synchronous write.
    assign rf_r_data = rf_mem[rf_r_addr];
    always @(posedge clk) begin
        if (rf_write_en) rf_mem[rf_w_addr] <= rf_w_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] fill_val(input logic [DW-1:0] base, input logic inc, input int k);
        return inc ? base + DW'(k) : base;
    endfunction

    // ---------------------------------------------------------------- monitor
    initial begin : monitor
        word_t         w;
        logic          prev_hold = 1'b0;
        logic [AW-1:0] prev_addr = '0;
        logic [DW-1:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_hold = 1'b0;
            end else begin
                check("port_addr_tied", 64'(rf_r_addr), 64'(rf_w_addr));
                if (busy) busy_cycles++;
                if (done) begin
                    done_cnt++;
                    check("done_with_busy", 64'(busy), 64'(1'b1));
                end
                if (rf_write_en) begin
                    check("write_expected", 64'(exp_wr.size() != 0), 64'(1'b1));
                    if (exp_wr.size() != 0) begin
                        w = exp_wr.pop_front();
                        check("write_addr", 64'(rf_w_addr), 64'(w.a));
                        check("write_data", 64'(rf_w_data), 64'(w.d));
                    end
                end
                if (out_valid) begin
                    valid_cycles++;
                    if (prev_hold) begin
                        check("hold_addr", 64'(out_addr), 64'(prev_addr));
                        check("hold_data", 64'(out_data), 64'(prev_data));
                    end
                    if (!out_ready) begin
                        stall_cycles++;
                    end else if (!abort) begin
                        words_seen++;
                        check("dump_expected", 64'(exp_dump.size() != 0), 64'(1'b1));
                        if (exp_dump.size() != 0) begin
                            w = exp_dump.pop_front();
                            check("dump_addr", 64'(out_addr), 64'(w.a));
                            check("dump_data", 64'(out_data), 64'(w.d));
                        end
                    end
                end
                prev_hold = out_valid && !out_ready && !abort;
                prev_addr = out_addr;
                prev_data = out_data;
            end
        end
    end

    // ------------------------------------------------------- downstream ready
    initial begin : ready_driver
        forever begin
            @(posedge clk);
            #1;
            if (out_valid && int'(out_addr) == stall_addr && stall_done < stall_len) begin
                out_ready = 1'b0;
                stall_done++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------ tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic m, input logic inc, input logic [DW-1:0] base);
        word_t w;
        start     = 1'b1;
        mode      = m;
        fill_inc  = inc;
        fill_base = base;
        for (int k = 0; k < NR; k++) begin
            w.a = AW'(k);
            w.d = m ? fill_val(base, inc, k) : model_mem[k];
            if (m) exp_wr.push_back(w);
            else   exp_dump.push_back(w);
        end
        cyc();
        start = 1'b0;
    endtask

    task automatic model_fill(input logic [DW-1:0] base, input logic inc, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) model_mem[k] = fill_val(base, inc, k);
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (!busy) break;
            cyc();
        end
        check({name, "_idle"}, 64'(busy), 64'(1'b0));
    endtask

    task automatic run_dump(input string name, input int busy_exp);
        int b0;
        int w0;
        int d0;
        b0 = busy_cycles;
        w0 = words_seen;
        d0 = done_cnt;
        issue(1'b0, 1'b0, '0);
        wait_idle(name, 300);
        check({name, "_words"}, 64'(words_seen - w0), 64'(NR));
        check({name, "_busy_cycles"}, 64'(busy_cycles - b0), 64'(busy_exp));
        check({name, "_done"}, 64'(done_cnt - d0), 64'(1));
        check({name, "_left"}, 64'(exp_dump.size()), 64'(0));
    endtask

    // --------------------------------------------------------------- sequence
    initial begin : main
        int b0;
        int d0;
        int v0;
        int s0;
        int i;

        for (int k = 0; k < NR; k++) model_mem[k] = '0;

        // Reset state: every output 0 while reset is held.
        #3;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_wen", 64'(rf_write_en), 64'(0));
        check("rst_addr", 64'({rf_r_addr, rf_w_addr, out_addr}), 64'(0));
        check("rst_data", 64'({rf_w_data, out_data}), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        #20 reset = 1'b1;
        cyc();

        // 1: constant fill.
        b0 = busy_cycles;
        d0 = done_cnt;
        issue(1'b1, 1'b0, 32'hA5A5_0000);
        wait_idle("t1", 100);
        check("t1_writes_left", 64'(exp_wr.size()), 64'(0));
        check("t1_busy_cycles", 64'(busy_cycles - b0), 64'(33));
        check("t1_done", 64'(done_cnt - d0), 64'(1));
        model_fill(32'hA5A5_0000, 1'b0, 0, NR - 1);
        check("t1_rf0", 64'(rf_mem[0]), 64'(32'hA5A5_0000));
        check("t1_rf31", 64'(rf_mem[31]), 64'(32'hA5A5_0000));

        // 2: incrementing fill, then full-rate dump.
        issue(1'b1, 1'b1, 32'd100);
        wait_idle("t2_fill", 100);
        check("t2_writes_left", 64'(exp_wr.size()), 64'(0));
        model_fill(32'd100, 1'b1, 0, NR - 1);
        check("t2_model_pin", 64'(model_mem[3]), 64'(32'd103));
        check("t2_rf31", 64'(rf_mem[31]), 64'(32'd131));
        v0 = valid_cycles;
        run_dump("t2_dump", 65);
        check("t2_valid_cycles", 64'(valid_cycles - v0), 64'(32));

        // 3: dump with a 5-cycle stall on word 3.
        stall_addr = 3;
        stall_len  = 5;
        stall_done = 0;
        s0 = stall_cycles;
        run_dump("t3", 70);
        check("t3_stall_cycles", 64'(stall_cycles - s0), 64'(5));
        stall_addr = -1;

        // 4: abort on word 10, then a fresh dump from addr 0.
        d0 = done_cnt;
        issue(1'b0, 1'b0, '0);
        for (i = 0; i < 100; i++) begin
            if (out_valid && out_addr == AW'(10)) break;
            cyc();
        end
        check("t4_word10_seen", 64'(out_addr), 64'(10));
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("t4_busy", 64'(busy), 64'(0));
        check("t4_valid", 64'(out_valid), 64'(0));
        check("t4_wen", 64'(rf_write_en), 64'(0));
        check("t4_words_left", 64'(exp_dump.size()), 64'(22));
        exp_dump.delete();
        cyc();
        cyc();
        check("t4_no_done", 64'(done_cnt - d0), 64'(0));
        run_dump("t4_restart", 65);

        // 5: reset while filling address 7.
        issue(1'b1, 1'b1, 32'hDEAD_0000);
        for (i = 0; i < 100; i++) begin
            if (rf_write_en && rf_w_addr == AW'(7)) break;
            cyc();
        end
        check("t5_addr7_seen", 64'(rf_w_addr), 64'(7));
        #2 reset = 1'b0;
        #1;
        check("t5_wen", 64'(rf_write_en), 64'(0));
        check("t5_busy", 64'(busy), 64'(0));
        check("t5_waddr", 64'(rf_w_addr), 64'(0));
        check("t5_wdata", 64'(rf_w_data), 64'(0));
        check("t5_valid_done", 64'({out_valid, done}), 64'(0));
        check("t5_writes_left", 64'(exp_wr.size()), 64'(25));
        exp_wr.delete();
        #20 reset = 1'b1;
        cyc();
        cyc();
        check("t5_stays_idle", 64'({busy, rf_write_en}), 64'(0));
        model_fill(32'hDEAD_0000, 1'b1, 0, 6);
        check("t5_model_pin", 64'(model_mem[8]), 64'(32'd108));
        for (int k = 0; k < NR; k++) check($sformatf("t5_rf%0d", k), 64'(rf_mem[k]), 64'(model_mem[k]));

        // 6: start while busy is ignored; start with abort in IDLE launches nothing.
        b0 = busy_cycles;
        d0 = done_cnt;
        issue(1'b1, 1'b1, 32'd5);
        cyc();
        cyc();
        start     = 1'b1;
        mode      = 1'b0;
        fill_base = 32'h0000_FFFF;
        cyc();
        start = 1'b0;
        wait_idle("t6_fill", 100);
        check("t6_busy_cycles", 64'(busy_cycles - b0), 64'(33));
        check("t6_done", 64'(done_cnt - d0), 64'(1));
        check("t6_writes_left", 64'(exp_wr.size()), 64'(0));
        model_fill(32'd5, 1'b1, 0, NR - 1);
        check("t6_model_pin", 64'(model_mem[31]), 64'(32'd36));
        start = 1'b1;
        abort = 1'b1;
        mode  = 1'b1;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t6_abort_wins", 64'({busy, rf_write_en}), 64'(0));
            cyc();
        end
        run_dump("t6_dump", 65);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_reg_file_sequencer
